// File: rtl/la_iopadctrl.sv
// Core-side pad control for one padring side: per-pin a/oe/ie/cfg registers,
// zp synchronizer with edge-triggered status and a level irq, behind a valid/ready register port.

module la_iopadctrl_pin #(
  parameter int              CFGW   = 8,
  parameter logic [CFGW-1:0] CFGRST = '0
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            zp,
  input  logic            rise_en,
  input  logic            fall_en,
  input  logic            clr,
  input  logic            cfg_we,
  input  logic [CFGW-1:0] cfg_wdata,
  output logic            sync,
  output logic            status,
  output logic [CFGW-1:0] cfg
);
  logic s1, s2, s3, edge_hit;

  assign sync     = s2;
  assign edge_hit = (s2 & ~s3 & rise_en) | (~s2 & s3 & fall_en);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      status <= 1'b0;
      cfg    <= CFGRST;
    end else begin
      s1     <= zp;
      s2     <= s1;
      s3     <= s2;
      // a new edge in the same cycle as a W1C keeps the bit set
      status <= (status & ~clr) | edge_hit;
      if (cfg_we) cfg <= cfg_wdata;
    end
  end
endmodule

module la_iopadctrl #(
  parameter int              NPINS  = 8,
  parameter int              CFGW   = 8,
  parameter int              AW     = 8,
  parameter logic [CFGW-1:0] CFGRST = '0
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [AW-1:0]         req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [NPINS-1:0]      a,
  output logic [NPINS-1:0]      oe,
  output logic [NPINS-1:0]      ie,
  output logic [NPINS*CFGW-1:0] cfg,
  input  logic [NPINS-1:0]      zp,
  output logic                  irq
);
  logic                        acc, aligned, hit, wr;
  logic [31:0]                 addr, rdata_c;
  logic [NPINS-1:0]            out_q, oe_q, ie_q, irqen_q, rise_q, fall_q;
  logic [NPINS-1:0]            sync, status, clr, cfg_we, wbits;
  logic [NPINS-1:0][CFGW-1:0]  cfg_q;
  logic                        unused_wdata;

  assign addr         = 32'(req_addr);
  assign wbits        = req_wdata[NPINS-1:0];
  assign unused_wdata = ^req_wdata;
  assign aligned      = (req_addr[1:0] == 2'b00);
  assign req_ready    = !rsp_valid || rsp_ready;
  assign acc          = req_valid && req_ready;
  assign wr           = acc && req_write && hit;
  assign clr          = (wr && addr == 32'h14) ? wbits : '0;

  assign a   = out_q;
  assign oe  = oe_q;
  assign ie  = ie_q;
  assign cfg = cfg_q;

  always_comb begin
    hit     = 1'b0;
    rdata_c = '0;
    if (aligned) begin
      case (addr)
        32'h00: begin hit = 1'b1; rdata_c = 32'(out_q);   end
        32'h04: begin hit = 1'b1; rdata_c = 32'(oe_q);    end
        32'h08: begin hit = 1'b1; rdata_c = 32'(ie_q);    end
        32'h0C: begin hit = 1'b1; rdata_c = 32'(sync);    end
        32'h10: begin hit = 1'b1; rdata_c = 32'(irqen_q); end
        32'h14: begin hit = 1'b1; rdata_c = 32'(status);  end
        32'h18: begin hit = 1'b1; rdata_c = 32'(rise_q);  end
        32'h1C: begin hit = 1'b1; rdata_c = 32'(fall_q);  end
        default:
          for (int i = 0; i < NPINS; i++)
            if (addr == 32'h40 + 32'(4 * i)) begin
              hit     = 1'b1;
              rdata_c = 32'(cfg_q[i]);
            end
      endcase
    end
  end

  for (genvar i = 0; i < NPINS; i++) begin : g_pin
    assign cfg_we[i] = wr && (addr == 32'h40 + 32'(4 * i));
    la_iopadctrl_pin #(.CFGW(CFGW), .CFGRST(CFGRST)) u_pin (
      .clk       (clk),
      .nreset    (nreset),
      .zp        (zp[i]),
      .rise_en   (rise_q[i]),
      .fall_en   (fall_q[i]),
      .clr       (clr[i]),
      .cfg_we    (cfg_we[i]),
      .cfg_wdata (req_wdata[CFGW-1:0]),
      .sync      (sync[i]),
      .status    (status[i]),
      .cfg       (cfg_q[i])
    );
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_q   <= '0;
      oe_q    <= '0;
      ie_q    <= '0;
      irqen_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else if (wr) begin
      case (addr)
        32'h00:  out_q   <= wbits;
        32'h04:  oe_q    <= wbits;
        32'h08:  ie_q    <= wbits;
        32'h10:  irqen_q <= wbits;
        32'h18:  rise_q  <= wbits;
        32'h1C:  fall_q  <= wbits;
        default: ;
      endcase
    end
  end

  // response is held until consumed; a new accept can only happen once it is
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (acc) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= req_write ? 32'h0 : rdata_c;
      rsp_err   <= !hit;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) irq <= 1'b0;
    else         irq <= |(status & irqen_q);
  end
endmodule

// File: tb/tb_la_iopadctrl.sv
// Directed bench for la_iopadctrl: stimulus pushes expected responses, a monitor pops them.

module tb_la_iopadctrl;
  logic        clk = 1'b0;
  logic        nreset, req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err, irq;
  logic [7:0]  req_addr, a, oe, ie, zp;
  logic [31:0] req_wdata, rsp_rdata;
  logic [63:0] cfg;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;

  always #5 clk = ~clk;

  la_iopadctrl #(.NPINS(8), .CFGW(8), .AW(8), .CFGRST(8'h00)) dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .a(a), .oe(oe), .ie(ie), .cfg(cfg), .zp(zp), .irq(irq)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every consumed response is matched against the oldest expectation
  always @(negedge clk) begin
    if (nreset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected got rdata %h err %b want none", rsp_rdata, rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e[31:0]));
        chk("rsp_err", 64'(rsp_err), 64'(mon_e[32]));
      end
    end
  end

  // called just after a posedge; returns just after the accepting posedge
  task automatic req(input logic wr, input logic [7:0] ad, input logic [31:0] wd,
                     input logic [31:0] er, input logic ee);
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = ad; req_wdata = wd;
    @(negedge clk);
    while (!req_ready && n < 50) begin n++; @(negedge clk); end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_timeout got req_ready 0 want 1 addr %h", ad);
    end else begin
      exp_q.push_back({ee, er});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  initial begin
    nreset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; zp = 8'hFF;
    repeat (3) @(posedge clk); #1;
    chk("reset_outs", {a, oe, ie, 7'd0, irq}, 32'h0);
    chk("reset_cfg", cfg, 64'h0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    nreset = 1'b1;
    repeat (3) @(posedge clk); #1;
    req(0, 8'h0C, 0, 32'hFF, 0);                 // IN after sync latency

    // write then read with backpressure
    req(1, 8'h00, 32'hA5, 32'h0, 0);
    chk("a_after_write", 64'(a), 64'hA5);
    drain();
    rsp_ready = 1'b0;
    req(0, 8'h00, 0, 32'hA5, 0);
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold", {31'd0, rsp_valid, rsp_rdata, 31'd0, req_ready}, {31'd0, 1'b1, 32'hA5, 32'd0});
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain();

    // back-to-back write then read of the same register
    req(1, 8'h04, 32'h3C, 32'h0, 0);
    req(0, 8'h04, 0, 32'h3C, 0);
    chk("oe_out", 64'(oe), 64'h3C);

    // cfg packing and boundaries
    req(1, 8'h4C, 32'h5C, 32'h0, 0);
    chk("cfg_pack", cfg, 64'h00000000_5C000000);
    req(0, 8'h4C, 0, 32'h5C, 0);
    req(0, 8'h5C, 0, 32'h0, 0);                  // last pin, still mapped
    req(0, 8'h60, 0, 32'h0, 1);                  // one past the last pin
    drain();

    // edge interrupt
    req(1, 8'h18, 32'h01, 32'h0, 0);
    req(1, 8'h10, 32'h01, 32'h0, 0);
    drain();
    zp[0] = 1'b0;                                // falling edge, FALL disabled
    repeat (5) @(posedge clk); #1;
    req(0, 8'h14, 0, 32'h0, 0);
    drain();
    zp[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); chk("irq_not_yet", 64'(irq), 64'h0);
    @(negedge clk); chk("irq_set", 64'(irq), 64'h1);
    @(posedge clk); #1;
    req(0, 8'h14, 0, 32'h01, 0);
    drain();

    // W1C colliding with a fresh rising edge
    zp[0] = 1'b0;
    repeat (5) @(posedge clk); #1;
    zp[0] = 1'b1;
    repeat (2) @(posedge clk); #1;
    req(1, 8'h14, 32'h01, 32'h0, 0);            // accepted on the edge that sets STATUS
    @(negedge clk); chk("irq_hold_collision", 64'(irq), 64'h1);
    @(posedge clk); #1;
    req(0, 8'h14, 0, 32'h01, 0);
    req(1, 8'h14, 32'h01, 32'h0, 0);
    req(0, 8'h14, 0, 32'h0, 0);
    drain();
    chk("irq_cleared", 64'(irq), 64'h0);

    // errors
    req(0, 8'h20, 0, 32'h0, 1);
    req(1, 8'h02, 32'hFF, 32'h0, 1);
    req(0, 8'h00, 0, 32'hA5, 0);
    drain();
    chk("a_unchanged", 64'(a), 64'hA5);

    // reset while a response is pending
    req(1, 8'h08, 32'h0F, 32'h0, 0);
    drain();
    rsp_ready = 1'b0;
    req(0, 8'h00, 0, 32'hA5, 0);
    #3; nreset = 1'b0; #1;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("midrst_outs", {a, oe, ie, 7'd0, irq}, 32'h0);
    chk("midrst_cfg", cfg, 64'h0);
    exp_q.delete();                              // the in-flight read is lost
    @(posedge clk); #1;
    nreset = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req(0, 8'h00, 0, 32'h0, 0);
    req(0, 8'h4C, 0, 32'h0, 0);
    req(0, 8'h10, 0, 32'h0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
